usb_pkt_tx: RTL and testbench
=============================

USB_PKT_TX -- requirements
Module: usb_pkt_tx

Interface
REQ-001 SHALL have parameter MAX_PKT, default 64, maximum payload bytes per data packet.
REQ-002 SHALL have parameter IPG_CYCLES, default 4, inter-packet idle cycles (used only with USB_TX_IPG_EN).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  packet request from endpoint logic.
REQ-006 SHALL have port req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready.
REQ-007 SHALL have port req_pid  input  4  PID of packet to send, sampled at accept.
REQ-008 SHALL have port req_len  input  16  payload byte count, sampled at accept.
REQ-009 SHALL have port pld_data  input  8  payload byte from endpoint FIFO.
REQ-010 SHALL have port pld_valid  input  1  pld_data is valid.
REQ-011 SHALL have port pld_ready  output  1  one-cycle pop strobe; byte consumed when pld_valid && pld_ready.
REQ-012 SHALL have port utmi_data  output  8  byte to PHY.
REQ-013 SHALL have port utmi_valid  output  1  utmi_data valid.
REQ-014 SHALL have port utmi_ready  input  1  PHY accepts; transfer when utmi_valid && utmi_ready.
REQ-015 SHALL have port busy  output  1  high from accept until return to IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse after final byte of a packet transfers.
REQ-017 SHALL have port err_underrun  output  1  one-cycle pulse on payload underrun abort.

Function
REQ-018 SHALL implement states IDLE, PID, DATA, CRC_LO, CRC_HI and GAP (GAP only with USB_TX_IPG_EN).
REQ-019 SHALL, on accept in cycle N, present the PID byte {~req_pid, req_pid} with utmi_valid high in cycle N+1.
REQ-020 SHALL hold utmi_data and utmi_valid stable until utmi_ready; no byte dropped or duplicated under any ready pattern.
REQ-021 SHALL treat DATA0 (4'h3) and DATA1 (4'hB) as data packets: PID, payload, CRC_LO, CRC_HI; all other PIDs (ACK 4'h2, NAK 4'hA, STALL 4'hE, others) as PID-only.
REQ-022 SHALL clamp payload length to MAX_PKT when req_len > MAX_PKT; extra FIFO bytes are not popped.
REQ-023 SHALL, for data packets with length 0, go PID -> CRC_LO, sending CRC bytes 8'h00, 8'h00.
REQ-024 SHALL compute CRC16-USB over payload only: reflected polynomial 16'hA001, init 16'hFFFF, final inversion, low byte sent first.
REQ-025 SHALL use a 16-bit remaining-byte counter loaded at accept and decremented per payload transfer; DATA exits to CRC_LO when the last payload byte transfers.
REQ-026 SHALL assert pld_ready for exactly one cycle per payload byte, only when the output register is empty or transferring that cycle.
REQ-027 SHALL, if a payload byte is needed and pld_valid is low, abort: utmi_valid low next cycle, err_underrun pulse, no CRC sent, done not pulsed, enter IDLE (or GAP).
REQ-028 SHALL pulse done in the cycle after the final byte (PID for handshakes, CRC_HI for data) transfers.
REQ-029 SHALL ignore req_valid while busy; a request held high is accepted on the first IDLE cycle.

Reset
REQ-030 SHALL, on rst high, immediately clear utmi_valid, pld_ready, done, err_underrun, busy, counters and CRC, and enter IDLE, including mid-packet.
REQ-031 SHALL drive req_ready high and utmi_data 8'h00 after reset release.

Configuration
REQ-032 SHALL honour macro USB_TX_IPG_EN: defined -> after done or abort, stay IPG_CYCLES cycles in GAP with busy high, req_ready low; undefined -> return to IDLE in the same cycle done/err pulses, no GAP state.

Verification
REQ-033 SHALL cover: ACK request (pid 4'h2), utmi_ready held high -> single byte 8'hD2, done one cycle later, no pld_ready.
REQ-034 SHALL cover: DATA0, len 9, bytes 8'h31..8'h39 -> bytes 8'hC3, 31..39, 8'hC8, 8'hB4.
REQ-035 SHALL cover: DATA1 len 0 -> bytes 8'h4B, 8'h00, 8'h00, done pulse.
REQ-036 SHALL cover: DATA0 len 100, 100 bytes queued -> 64 payload bytes, 36 remain in FIFO.
REQ-037 SHALL cover: pld_valid dropped after byte 3 of len 8 -> err_underrun pulse, no CRC, no done, next request accepted.
REQ-038 SHALL cover: random utmi_ready stalls plus rst asserted mid-DATA -> byte stream identical to no-stall case; after reset utmi_valid low, req_ready high.

Source files
------------

// File: rtl/usb_pkt_tx_if.sv
// Handshake bundle for usb_pkt_tx: request, payload FIFO pop port, UTMI byte port and status.
// slave is the transmitter side; master is the endpoint/PHY side that drives it.
interface usb_pkt_tx_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_pid;
    logic [15:0] req_len;
    logic [7:0]  pld_data;
    logic        pld_valid;
    logic        pld_ready;
    logic [7:0]  utmi_data;
    logic        utmi_valid;
    logic        utmi_ready;
    logic        busy;
    logic        done;
    logic        err_underrun;

    modport master (
        output req_valid, req_pid, req_len, pld_data, pld_valid, utmi_ready,
        input  req_ready, pld_ready, utmi_data, utmi_valid, busy, done, err_underrun
    );

    modport slave (
        input  req_valid, req_pid, req_len, pld_data, pld_valid, utmi_ready,
        output req_ready, pld_ready, utmi_data, utmi_valid, busy, done, err_underrun
    );
endinterface

// File: rtl/usb_pkt_tx.sv
// USB packet transmitter: PID byte, optional payload with CRC16, byte-wise to a UTMI PHY.
// Optional macro USB_TX_IPG_EN adds an IPG_CYCLES-long GAP state after every packet.
module usb_pkt_tx #(
    parameter int MAX_PKT    = 64,
    parameter int IPG_CYCLES = 4
) (
    input logic         clk,
    input logic         rst,
    usb_pkt_tx_if.slave bus
);
`ifdef USB_TX_IPG_EN
    typedef enum logic [2:0] {S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_GAP} state_t;
    localparam state_t      END_STATE = (IPG_CYCLES > 0) ? S_GAP : S_IDLE;
    localparam logic [15:0] GAP_LOAD  = 16'(IPG_CYCLES - 1);
`else
    typedef enum logic [2:0] {S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI} state_t;
    localparam state_t      END_STATE = S_IDLE;
`endif
    localparam logic [15:0] MAX_LEN = 16'(MAX_PKT);

    state_t      state_reg;
    logic [15:0] rem_reg;
    logic [15:0] crc_reg;
    logic        is_data_reg;
    logic [7:0]  utmi_data_reg;
    logic        utmi_valid_reg;
    logic        req_ready_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        err_reg;
`ifdef USB_TX_IPG_EN
    logic [15:0] gap_reg;
`endif

    logic        xfer;
    logic        need_byte;
    logic        abort_evt;
    logic        done_evt;
    logic        finish;
    logic        req_is_data;
    logic [15:0] req_len_clamped;
    logic [15:0] crc_chain [0:8];

    // Byte-parallel CRC16 (reflected 0xA001): one stage per input bit, LSB first.
    assign crc_chain[0] = crc_reg ^ {8'h00, bus.pld_data};
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_crc
            assign crc_chain[gi+1] = crc_chain[gi][0] ? ({1'b0, crc_chain[gi][15:1]} ^ 16'hA001)
                                                      : {1'b0, crc_chain[gi][15:1]};
        end
    endgenerate

    assign req_is_data     = (bus.req_pid == 4'h3) || (bus.req_pid == 4'hB);
    assign req_len_clamped = (bus.req_len > MAX_LEN) ? MAX_LEN : bus.req_len;

    // The output register is always full in PID/DATA, so a new payload byte is
    // fetched exactly when the current byte leaves and more payload remains.
    assign xfer      = utmi_valid_reg && bus.utmi_ready;
    assign need_byte = xfer && (rem_reg != 16'd0) &&
                       ((state_reg == S_PID && is_data_reg) ||
                        (state_reg == S_DATA && rem_reg != 16'd1));
    assign abort_evt = need_byte && !bus.pld_valid;
    assign done_evt  = xfer && ((state_reg == S_PID && !is_data_reg) || state_reg == S_CRC_HI);
    assign finish    = abort_evt || done_evt;

    assign bus.pld_ready    = need_byte;
    assign bus.utmi_data    = utmi_data_reg;
    assign bus.utmi_valid   = utmi_valid_reg;
    assign bus.req_ready    = req_ready_reg;
    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
    assign bus.err_underrun = err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            rem_reg        <= '0;
            crc_reg        <= '0;
            is_data_reg    <= 1'b0;
            utmi_data_reg  <= 8'h00;
            utmi_valid_reg <= 1'b0;
            req_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
`ifdef USB_TX_IPG_EN
            gap_reg        <= '0;
`endif
        end else begin
            done_reg <= done_evt;
            err_reg  <= abort_evt;
            case (state_reg)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        state_reg      <= S_PID;
                        req_ready_reg  <= 1'b0;
                        busy_reg       <= 1'b1;
                        utmi_valid_reg <= 1'b1;
                        utmi_data_reg  <= {~bus.req_pid, bus.req_pid};
                        is_data_reg    <= req_is_data;
                        rem_reg        <= req_is_data ? req_len_clamped : 16'd0;
                        crc_reg        <= 16'hFFFF;
                    end
                end
                S_PID: begin
                    if (xfer && is_data_reg) begin
                        if (rem_reg == 16'd0) begin
                            utmi_data_reg <= ~crc_reg[7:0];
                            state_reg     <= S_CRC_LO;
                        end else begin
                            state_reg <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        rem_reg <= rem_reg - 16'd1;
                        if (rem_reg == 16'd1) begin
                            utmi_data_reg <= ~crc_reg[7:0];
                            state_reg     <= S_CRC_LO;
                        end
                    end
                end
                S_CRC_LO: begin
                    if (xfer) begin
                        utmi_data_reg <= ~crc_reg[15:8];
                        state_reg     <= S_CRC_HI;
                    end
                end
                S_CRC_HI: begin
                end
`ifdef USB_TX_IPG_EN
                S_GAP: begin
                    if (gap_reg == 16'd0) begin
                        state_reg     <= S_IDLE;
                        req_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                    end else begin
                        gap_reg <= gap_reg - 16'd1;
                    end
                end
`endif
                default: state_reg <= S_IDLE;
            endcase

            if (need_byte && bus.pld_valid) begin
                utmi_data_reg <= bus.pld_data;
                crc_reg       <= crc_chain[8];
            end

            // Normal completion and underrun abort leave the packet the same way.
            if (finish) begin
                utmi_valid_reg <= 1'b0;
                state_reg      <= END_STATE;
                req_ready_reg  <= (END_STATE == S_IDLE);
                busy_reg       <= (END_STATE != S_IDLE);
`ifdef USB_TX_IPG_EN
                gap_reg        <= GAP_LOAD;
`endif
            end
        end
    end
endmodule

// File: tb/tb_usb_pkt_tx.sv
// Randomized self-checking bench for usb_pkt_tx against a packet-level reference model.
module tb_usb_pkt_tx;
    localparam int MAX_PKT = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_pkt_tx_if bus();
    usb_pkt_tx #(.MAX_PKT(MAX_PKT), .IPG_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] fifo[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    bit         exp_done;
    int         exp_left, exp_prdy;

    bit  want_req, stall;
    int  cyc = 0;
    int  done_cnt, err_cnt, prdy_cyc, acc_cyc, first_v_cyc, last_x_cyc, done_cyc;
    logic done_rr, done_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int b = 0; b < 8; b++) begin
            fb = r[0] ^ d[b];
            r  = r >> 1;
            if (fb) r = r ^ 16'hA001;
        end
        return r;
    endfunction

    // Expected wire bytes, completion kind, FIFO leftover and pop count from the packet rules.
    task automatic build_exp(input logic [3:0] pid, input logic [15:0] len);
        int n, avail;
        logic [15:0] crc;
        avail    = fifo.size();
        exp_q    = {};
        exp_q.push_back({~pid, pid});
        exp_done = 1'b1;
        exp_left = avail;
        exp_prdy = 0;
        if (pid == 4'h3 || pid == 4'hB) begin
            n   = (int'(len) > MAX_PKT) ? MAX_PKT : int'(len);
            crc = 16'hFFFF;
            if (n > avail) begin
                exp_done = 1'b0;
                for (int i = 0; i < avail; i++) exp_q.push_back(fifo[i]);
                exp_left = 0;
                exp_prdy = avail + 1;
            end else begin
                for (int i = 0; i < n; i++) begin
                    exp_q.push_back(fifo[i]);
                    crc = crc16_byte(crc, fifo[i]);
                end
                crc = ~crc;
                exp_q.push_back(crc[7:0]);
                exp_q.push_back(crc[15:8]);
                exp_left = avail - n;
                exp_prdy = n;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        bus.req_valid  = want_req;
        bus.utmi_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.pld_valid  = (fifo.size() > 0);
        bus.pld_data   = (fifo.size() > 0) ? fifo[0] : 8'h00;
        #1;
        if (bus.req_valid && bus.req_ready) begin
            want_req = 1'b0;
            acc_cyc  = cyc;
        end
        if (bus.utmi_valid && first_v_cyc < 0) first_v_cyc = cyc;
        if (bus.utmi_valid && bus.utmi_ready) begin
            got_q.push_back(bus.utmi_data);
            last_x_cyc = cyc;
        end
        if (bus.pld_ready) prdy_cyc++;
        if (bus.pld_ready && bus.pld_valid) fifo.delete(0);
        if (bus.done || bus.err_underrun) begin
            if (bus.done) done_cnt++;
            if (bus.err_underrun) err_cnt++;
            done_cyc  = cyc;
            done_rr   = bus.req_ready;
            done_busy = bus.busy;
        end
    endtask

    task automatic start_pkt(input logic [3:0] pid, input logic [15:0] len, input bit st);
        got_q    = {};
        done_cnt = 0; err_cnt = 0; prdy_cyc = 0;
        acc_cyc  = -1; first_v_cyc = -1; last_x_cyc = -1; done_cyc = -1;
        stall    = st;
        bus.req_pid = pid;
        bus.req_len = len;
        want_req = 1'b1;
    endtask

    task automatic run_pkt(input logic [3:0] pid, input logic [15:0] len, input bit st);
        int avail;
        avail = fifo.size();
        build_exp(pid, len);
        start_pkt(pid, len, st);
        for (int t = 0; t < 3000 && (done_cnt + err_cnt) == 0; t++) cycle();
        repeat (6) cycle();
        check("finish", done_cnt + err_cnt, 1);
        check("done", done_cnt, {31'd0, exp_done});
        check("err", err_cnt, {31'd0, !exp_done});
        check("nbytes", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
        check("fifo_left", fifo.size(), exp_left);
        check("pld_pops", prdy_cyc, exp_prdy);
        check("pid_lat", first_v_cyc, acc_cyc + 1);
        check("end_lat", done_cyc, last_x_cyc + 1);
`ifdef USB_TX_IPG_EN
        check("end_req_ready", done_rr, 1'b0);
        check("end_busy", done_busy, 1'b1);
`else
        check("end_req_ready", done_rr, 1'b1);
        check("end_busy", done_busy, 1'b0);
`endif
        $display("tx pid=%h len=%0d avail=%0d stall=%0d sent=%0d done=%0d err=%0d left=%0d",
                 pid, len, avail, st, got_q.size(), done_cnt, err_cnt, fifo.size());
    endtask

    initial begin
        logic [3:0] pid_tab [8];
        logic [3:0] pid;
        logic [15:0] len;
        int n, avail;
        pid_tab = '{4'h2, 4'hA, 4'hE, 4'h3, 4'hB, 4'h3, 4'hB, 4'h3};

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_pid = 4'h0; bus.req_len = 16'h0;
        bus.pld_valid = 1'b0; bus.pld_data = 8'h00; bus.utmi_ready = 1'b0;
        want_req = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_uvalid", bus.utmi_valid, 1'b0);
        rst = 1'b0;
        cycle();
        check("init_req_ready", bus.req_ready, 1'b1);
        check("init_uvalid", bus.utmi_valid, 1'b0);
        check("init_udata", bus.utmi_data, 8'h00);
        check("init_done", bus.done, 1'b0);
        check("init_err", bus.err_underrun, 1'b0);

        // ACK with FIFO bytes present: one byte, nothing popped
        fifo = '{8'hA5, 8'h5A, 8'h11, 8'h22};
        run_pkt(4'h2, 16'd0, 1'b0);
        if (got_q.size() > 0) check("ack_byte", got_q[0], 8'hD2);
        check("ack_no_pop", prdy_cyc, 0);

        // DATA0 "123456789": known CRC16-USB bytes C8 B4
        fifo = {};
        for (int i = 0; i < 9; i++) fifo.push_back(8'(8'h31 + i));
        run_pkt(4'h3, 16'd9, 1'b0);
        if (got_q.size() == 12) begin
            check("d0_pid", got_q[0], 8'hC3);
            check("d0_crc_lo", got_q[10], 8'hC8);
            check("d0_crc_hi", got_q[11], 8'hB4);
        end else check("d0_size", got_q.size(), 12);

        // DATA1 zero length
        fifo = {};
        run_pkt(4'hB, 16'd0, 1'b0);
        if (got_q.size() == 3) check("d1z_crc", {got_q[0], got_q[1], got_q[2]}, 24'h4B0000);
        else check("d1z_size", got_q.size(), 3);

        // Oversize request clamps to MAX_PKT
        fifo = {};
        for (int i = 0; i < 100; i++) fifo.push_back(8'($urandom));
        run_pkt(4'h3, 16'd100, 1'b1);
        check("clamp_left", fifo.size(), 36);

        // Underrun after 3 payload bytes, then a new request must go through
        fifo = '{8'h01, 8'h02, 8'h03};
        run_pkt(4'h3, 16'd8, 1'b0);
        check("ur_bytes", got_q.size(), 4);
        fifo = {};
        run_pkt(4'hA, 16'd0, 1'b1);

        // Reset in the middle of a stalled DATA packet
        fifo = {};
        for (int i = 0; i < 20; i++) fifo.push_back(8'($urandom));
        build_exp(4'h3, 16'd20);
        start_pkt(4'h3, 16'd20, 1'b1);
        for (int t = 0; t < 500 && got_q.size() < 8; t++) cycle();
        want_req = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_uvalid", bus.utmi_valid, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_pld_ready", bus.pld_ready, 1'b0);
        check("mid_rst_done", bus.done, 1'b0);
        check("mid_rst_nbytes", got_q.size(), 8);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("mid_rst_byte%0d", i), got_q[i], exp_q[i]);
        @(negedge clk);
        rst = 1'b0;
        fifo = {};
        cycle();
        check("post_rst_req_ready", bus.req_ready, 1'b1);
        check("post_rst_uvalid", bus.utmi_valid, 1'b0);
        check("post_rst_udata", bus.utmi_data, 8'h00);
        $display("tx reset mid-DATA after %0d bytes", 8);

        // Randomized packets: mixed PIDs, lengths, FIFO fill and PHY stalls
        for (int k = 0; k < 30; k++) begin
            pid = ($urandom_range(0, 5) == 0) ? 4'($urandom) : pid_tab[$urandom_range(0, 7)];
            len = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 90));
            n   = (int'(len) > MAX_PKT) ? MAX_PKT : int'(len);
            avail = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n) : n + $urandom_range(0, 5);
            fifo = {};
            for (int i = 0; i < avail; i++) fifo.push_back(8'($urandom));
            run_pkt(pid, len, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
